// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Fetch-stage bundle: imem request/response, redirect, decode.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      op;

    // master: the fetch unit; slave: memory + decoder side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_target,
        output instr_valid, instr, instr_pc, op,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_target,
        input  instr_valid, instr, instr_pc, op,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : In-order instruction fetch with credit-limited buffer and
//                redirect flush of buffered and in-flight words.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0]    c_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0]    c_ALIGN = ~XLEN'(3);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_CNT_W-1:0] r_occ;
    logic [c_CNT_W-1:0] r_out;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [XLEN-1:0]    r_buf_data [DEPTH];
    logic [XLEN-1:0]    r_buf_pc   [DEPTH];

    logic [c_CNT_W:0]   w_inuse;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_head_valid;
    logic [XLEN-1:0]    w_target;
    logic [c_CNT_W-1:0] w_out_after_rsp;

    // Credit uses registered counts only, so a same-cycle pop never frees a slot
    assign w_inuse         = {1'b0, r_occ} + {1'b0, r_out};
    assign w_req_valid     = !rst && !bus.redirect && (w_inuse < c_DEPTH);
    assign w_req_fire      = w_req_valid && bus.imem_req_ready;
    assign w_head_valid    = (r_occ != '0);
    assign w_pop           = w_head_valid && bus.instr_ready;
    assign w_push          = bus.imem_rsp_valid && !bus.redirect && (r_drop == '0);
    assign w_target        = bus.redirect_target & c_ALIGN;
    assign w_out_after_rsp = r_out - c_CNT_W'(bus.imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_occ      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_out <= w_out_after_rsp + c_CNT_W'(w_req_fire);
            if (bus.redirect) begin
                // Everything still in flight belongs to the abandoned path
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_occ      <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_drop     <= w_out_after_rsp;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + c_STEP;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + c_STEP;
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_occ <= r_occ + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
                if (bus.imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= bus.imem_rsp_data;
            r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.instr_valid    = w_head_valid;
    assign bus.instr          = w_head_valid ? r_buf_data[r_rd_ptr] : '0;
    assign bus.instr_pc       = w_head_valid ? r_buf_pc[r_rd_ptr]   : '0;
    assign bus.op             = w_head_valid ? r_buf_data[r_rd_ptr][6:0] : 7'd0;
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Randomized scoreboard bench for fetch_unit with memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    localparam int          c_DEPTH    = 2;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (c_RESET_PC),
        .DEPTH    (c_DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    mreq_t       memq [$];
    exp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          epoch = 0;
    int          last_due = 0;
    logic [31:0] model_fetch = c_RESET_PC;
    logic        rst_prev = 1'b1;
    logic        rst_req  = 1'b1;
    int          req_rdy_pct = 100;
    int          ins_rdy_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          redir_permille = 0;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;
    logic        t5_mode = 1'b0;
    logic        t5_hit  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15) ^ 32'h1357_2468;
        return h;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus: drives one cycle at the falling edge, then updates the reference
    task automatic cycle();
        mreq_t cur;
        logic  have_rsp;
        int    due;
        @(negedge clk);
        cyc++;
        rst_prev = rst;
        rst      = rst_req;
        have_rsp = 1'b0;
        cur      = '{addr: '0, data: '0, due: 0, epoch: 0};
        if (rst) begin
            memq.delete();
            exp_q.delete();
            epoch       = 0;
            last_due    = cyc;
            model_fetch = c_RESET_PC;
            bus.imem_req_ready  = 1'b1;
            bus.imem_rsp_valid  = 1'b0;
            bus.imem_rsp_data   = $urandom;
            bus.redirect        = 1'b0;
            bus.redirect_target = $urandom;
            bus.instr_ready     = 1'b1;
            return;
        end
        bus.imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        bus.instr_ready    = ($urandom_range(99) < ins_rdy_pct);
        if (force_redir) begin
            bus.redirect        = 1'b1;
            bus.redirect_target = force_target;
        end else begin
            bus.redirect        = ($urandom_range(999) < redir_permille);
            bus.redirect_target = $urandom;
        end
        if (t5_mode) begin
            if (exp_q.size() == 2 && exp_q[0].pc == 32'h8) begin
                bus.instr_ready     = 1'b1;
                bus.redirect        = 1'b1;
                bus.redirect_target = 32'h0000_0300;
                t5_hit              = 1'b1;
            end else begin
                bus.instr_ready = !(exp_q.size() != 0 && exp_q[0].pc == 32'h8);
                bus.redirect    = 1'b0;
            end
        end
        if (memq.size() != 0 && memq[0].due <= cyc) begin
            cur                = memq.pop_front();
            have_rsp           = 1'b1;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = cur.data;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        #3;
        if (bus.redirect) begin
            exp_q.delete();
            epoch++;
            model_fetch = bus.redirect_target & 32'hFFFF_FFFC;
        end else begin
            if (have_rsp && cur.epoch == epoch)
                exp_q.push_back('{pc: cur.addr, data: cur.data});
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: model_fetch, data: mem_word(model_fetch), due: due, epoch: epoch});
                model_fetch = model_fetch + 32'd4;
            end
        end
    endtask

    // Monitor: samples between edges and compares against the reference
    initial begin
        exp_t e;
        int   inuse;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("req_valid_in_reset", 32'(bus.imem_req_valid), 32'd0);
                if (rst_prev) begin
                    check("reset_instr_valid", 32'(bus.instr_valid), 32'd0);
                    check("reset_instr", bus.instr, 32'd0);
                    check("reset_instr_pc", bus.instr_pc, 32'd0);
                    check("reset_op", 32'(bus.op), 32'd0);
                end
            end else begin
                inuse = exp_q.size() + memq.size() + (bus.imem_rsp_valid ? 1 : 0);
                check("req_valid", 32'(bus.imem_req_valid),
                      32'(!bus.redirect && inuse < c_DEPTH));
                if (bus.imem_req_valid)
                    check("req_addr", bus.imem_req_addr, model_fetch);
                check("instr_valid", 32'(bus.instr_valid), 32'(exp_q.size() != 0));
                if (bus.instr_valid && exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("instr_pc", bus.instr_pc, e.pc);
                    check("instr", bus.instr, e.data);
                    check("op", 32'(bus.op), 32'(e.data[6:0]));
                    if (bus.instr_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.instr_ready     = 1'b1;

        rst_req = 1'b1;
        repeat (3) cycle();
        rst_req = 1'b0;

        // Streaming with single-cycle memory
        repeat (40) cycle();

        // Decode stall fills the buffer, then releases
        ins_rdy_pct = 0;
        repeat (10) cycle();
        ins_rdy_pct = 100;
        repeat (10) cycle();

        // Memory backpressure holds the request address
        req_rdy_pct = 0;
        repeat (5) cycle();
        req_rdy_pct = 100;
        repeat (10) cycle();

        // Redirect with two requests in flight at latency 3
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 20 && memq.size() < 2; k++) cycle();
        total++;
        if (memq.size() < 2) begin
            bad++;
            $display("FAIL t4_setup: got %0d in flight required 2", memq.size());
        end
        force_redir  = 1'b1;
        force_target = 32'h0000_0100;
        cycle();
        force_redir = 1'b0;
        repeat (20) cycle();

        // Mid-run reset, then redirect while popping the branch at PC 0x8
        lat_min = 1;
        lat_max = 1;
        rst_req = 1'b1;
        repeat (2) cycle();
        rst_req = 1'b0;
        t5_mode = 1'b1;
        for (int k = 0; k < 40 && !t5_hit; k++) cycle();
        t5_mode = 1'b0;
        total++;
        if (!t5_hit) begin
            bad++;
            $display("FAIL t5_setup: got no branch-pop window required one");
        end
        repeat (10) cycle();

        // Misaligned target, immediately superseded
        force_redir  = 1'b1;
        force_target = 32'h0000_0203;
        cycle();
        force_target = 32'h0000_0040;
        cycle();
        force_redir = 1'b0;
        repeat (15) cycle();

        // Randomized segments
        for (int s = 0; s < 10; s++) begin
            req_rdy_pct    = $urandom_range(100, 30);
            ins_rdy_pct    = $urandom_range(100, 30);
            lat_min        = 1;
            lat_max        = $urandom_range(4, 1);
            redir_permille = $urandom_range(60, 0);
            repeat (200) cycle();
        end

        redir_permille = 0;
        req_rdy_pct    = 100;
        ins_rdy_pct    = 100;
        repeat (30) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
